// File: rtl/jk_ff_bist.sv
// Stimulus driver and lock-step response checker for one JK flip-flop.
// Drives a fixed j/k sequence, models q internally, and counts mismatches.
module jk_ff_bist #(
  parameter int NUM_VECTORS = 16,
  parameter int IDX_W       = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_j;
  logic             r_k;
  logic             r_m;
  logic             r_chk;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_inc;
  logic [IDX_W:0]   w_vec;
  logic             w_j_next;
  logic             w_k_next;
  logic             w_m_next;
  logic             w_mis;
  logic             w_cmp;

  assign w_idx_inc = r_idx + IDX_W'(1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  w_next = S_RUN;
      S_RUN:   if (r_idx == LAST) w_next = S_CHECK;
      S_CHECK: w_next = S_DONE;
      S_DONE:  if (start) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  // j/k are registered, so they are chosen for the state being entered
  always_comb begin
    w_vec    = '0;
    w_j_next = 1'b0;
    w_k_next = 1'b0;
    if (r_state == S_RUN) w_vec = {1'b0, w_idx_inc};
    if (w_next == S_INIT) begin
      w_k_next = 1'b1;
    end else if (w_next == S_RUN) begin
      w_j_next = w_vec[0];
      w_k_next = w_vec[1];
    end
  end

  always_comb begin
    w_m_next = r_m;
    unique case ({r_j, r_k})
      2'b10:   w_m_next = 1'b1;
      2'b01:   w_m_next = 1'b0;
      2'b11:   w_m_next = ~r_m;
      default: w_m_next = r_m;
    endcase
  end

  // case inequality so unknown DUT outputs count as errors
  assign w_mis = (q_in !== r_m) || (qbar_in !== ~r_m);
  assign w_cmp = r_chk &&
                 ((r_state == S_RUN) || (r_state == S_CHECK));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_m     <= 1'b0;
      r_chk   <= 1'b0;
      r_err   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_j     <= w_j_next;
      r_k     <= w_k_next;
      if (r_state == S_INIT) begin
        r_m   <= 1'b0;
        r_chk <= 1'b1;
        r_idx <= '0;
      end else if (r_state == S_RUN) begin
        r_m   <= w_m_next;
        r_idx <= w_idx_inc;
      end
      if ((w_next == S_DONE) || (w_next == S_IDLE))
        r_chk <= 1'b0;
      if (w_next == S_INIT)
        r_err <= '0;
      else if (w_cmp && w_mis && (r_err != '1))
        r_err <= r_err + ERR_W'(1);
    end
  end

  assign j         = r_j;
  assign k         = r_k;
  assign busy      = (r_state == S_INIT) ||
                     (r_state == S_RUN) ||
                     (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == '0);
  assign err_count = r_err;
  assign vec_idx   = r_idx;

endmodule

// File: doc/jk_ff_bist.md
Name: jk_ff_bist

Overview:
- Synthesizable stimulus driver and response checker for a single JK flip-flop (ports j, k, clk in; q, qbar out). It sits on the opposite side of the flip-flop interface from the DUT.
- Drives a deterministic j/k vector sequence and runs an internal JK reference model in lock-step with the DUT.
- Compares the returned q/qbar every cycle and reports an error count plus a pass flag.
- Used for on-chip self-test and as a reusable checker in flip-flop benches.

Parameters:
- NUM_VECTORS, 16, number of RUN vectors applied after initialisation; legal range 2..2**IDX_W.
- IDX_W, 4, width of the vector index.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, shared with the DUT.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a test; ignored while busy.
- j  output  1  J stimulus to the DUT, registered.
- k  output  1  K stimulus to the DUT, registered.
- q_in  input  1  DUT q.
- qbar_in  input  1  DUT qbar.
- busy  output  1  high from the INIT state through the CHECK state.
- done  output  1  high in the DONE state.
- pass  output  1  done && (err_count == 0).
- err_count  output  ERR_W  number of mismatching check cycles; saturates at all-ones.
- vec_idx  output  IDX_W  index of the vector currently driven on j/k.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: rst_n low at a rising edge forces state IDLE. Outputs after reset: j=0, k=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0. Model register m=0, check-enable chk=0.
- Reset mid-test: same as above. The test is abandoned with no done pulse.
- States: IDLE, INIT, RUN, CHECK, DONE.
- IDLE: j=k=0. start=1 -> INIT, err_count cleared.
- INIT (1 cycle):
  - Drives j=0, k=1 so the DUT is forced to q=0.
  - At the exiting edge: m<=0, chk<=1, vec_idx<=0, go to RUN.
- RUN (NUM_VECTORS cycles):
  - Drives vector v = vec_idx with j=v[0], k=v[1] (sequence 00,10,01,11 repeating).
  - Each edge: m updates with the JK rule using the driven j/k: 00 hold, 10 set, 01 reset, 11 toggle. vec_idx increments.
  - After vector NUM_VECTORS-1 is applied, go to CHECK.
- CHECK (1 cycle): j=k=0. Performs the final comparison, then goes to DONE.
- DONE: done=1, busy=0, j=k=0. err_count and pass hold. start=1 -> INIT, which clears err_count and done.
- Check rule:
  - On every edge where chk=1, in states RUN and CHECK, compare pre-edge values.
  - Mismatch if (q_in != m) or (qbar_in != ~m). Each mismatching cycle adds exactly 1 to err_count.
  - chk clears on entry to DONE or IDLE.
- Check count: NUM_VECTORS+1 checks per test (one after INIT, one after each vector).
- Latency: a vector driven after edge t is captured by the DUT and the model at edge t+1, and checked at edge t+2.
- Expected q after each vector for the default run: INIT 0; v0..v3: 0,1,0,1; every later group of four: 1,1,0,1.
- Boundary conditions:
  - start asserted while busy: ignored.
  - start on the same edge that enters DONE: ignored (it is sampled in DONE only).
  - X/Z on q_in counts as a mismatch.
  - err_count never wraps.
- pass is combinational from registered state.

Test Plan:
- Correct JK DUT, NUM_VECTORS=16, start pulse -> busy for 18 cycles, done=1, err_count=0, pass=1, final q_in=1.
- q_in stuck at 0 (qbar_in=~q_in), NUM_VECTORS=16 -> err_count=11, pass=0.
- q_in stuck at 1 (qbar_in=~q_in), NUM_VECTORS=16 -> err_count=6, pass=0.
- Correct DUT with qbar_in tied equal to q_in, NUM_VECTORS=4 -> every check fails, err_count=5.
- rst_n low for 1 cycle during RUN at vec_idx=7 -> next cycle IDLE, j=k=0, busy=0, done=0, err_count=0; a new start completes with pass=1.
- ERR_W=2, q_in stuck at 0, NUM_VECTORS=16 -> err_count saturates at 3; start pulses during RUN have no effect; a start in DONE restarts with err_count cleared to 0.
